apb_byte_master: RTL

- APB initiator driven by a byte stream; the host-side counterpart of the peripheral APB slaves in the SoC.
- Parses read/write command frames from a byte source (typically a uart_rx instance), issues one APB transfer per frame, and returns a status/data frame on a byte sink (typically a uart_tx instance).
- Used as a debug bridge: a UART link gives full access to the peripheral APB space.

---
 rtl/apb_byte_master_if.sv | 30 +++
 rtl/apb_byte_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_byte_master_if.sv
// Byte-stream and APB signal bundle for apb_byte_master.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb_byte_master_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
);
  logic [7:0]                rx_data_i;
  logic                      rx_valid_i;
  logic                      rx_ready_o;
  logic [7:0]                tx_data_o;
  logic                      tx_valid_o;
  logic                      tx_ready_i;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, PRDATA, PREADY, PSLVERR,
    output rx_ready_o, tx_data_o, tx_valid_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, PRDATA, PREADY, PSLVERR,
    input  rx_ready_o, tx_data_o, tx_valid_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_byte_master.sv
// Byte-stream to APB debug bridge: parses W/R command frames, runs one APB transfer, returns K/E status (+ read data).
// Optional ACCESS-phase timeout enabled by defining APB_BYTE_MASTER_TIMEOUT_EN.
module apb_byte_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RSTN,
  apb_byte_master_if.master   bus,
  output logic                busy_o
);

  if (APB_ADDR_WIDTH < 1 || APB_ADDR_WIDTH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_byte_master: parameter out of range");
  end

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ST_OK  = 8'h4B;
  localparam logic [7:0] ST_ERR = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_DATA, S_SETUP, S_ACCESS, S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [7:0]                addr_lo_q, addr_lo_d;
  logic [7:0]                addr_hi_q, addr_hi_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [7:0]                status_q, status_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rx_ready_q, rx_ready_d;
  logic                      tx_valid_q, tx_valid_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      busy_q, busy_d;
  logic                      rx_fire, tx_fire;

`ifdef APB_BYTE_MASTER_TIMEOUT_EN
  localparam logic [7:0]  ST_TMO = 8'h54;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign rx_fire = bus.rx_valid_i & rx_ready_q;
  assign tx_fire = tx_valid_q & bus.tx_ready_i;

  // State and datapath registers; bus outputs are registered copies of the next-state decode.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_lo_q  <= '0;
      addr_hi_q  <= '0;
      wdata_q    <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rdata_q    <= '0;
      status_q   <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
`ifdef APB_BYTE_MASTER_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_lo_q  <= addr_lo_d;
      addr_hi_q  <= addr_hi_d;
      wdata_q    <= wdata_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
`ifdef APB_BYTE_MASTER_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_lo_d = addr_lo_q;
    addr_hi_d = addr_hi_q;
    wdata_d   = wdata_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
`ifdef APB_BYTE_MASTER_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (rx_fire && (bus.rx_data_i == CMD_WR || bus.rx_data_i == CMD_RD)) begin
          pwrite_d = (bus.rx_data_i == CMD_WR);
          state_d  = S_ADDR0;
        end
      end
      S_ADDR0: begin
        if (rx_fire) begin
          addr_lo_d = bus.rx_data_i;
          state_d   = S_ADDR1;
        end
      end
      S_ADDR1: begin
        if (rx_fire) begin
          addr_hi_d = bus.rx_data_i;
          cnt_d     = '0;
          if (pwrite_q) begin
            state_d = S_DATA;
          end else begin
            // Reads go straight to SETUP; PWDATA keeps its previous value.
            paddr_d = APB_ADDR_WIDTH'({bus.rx_data_i, addr_lo_q});
            state_d = S_SETUP;
          end
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          wdata_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_data_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            // APB-visible address/data only change on entry to SETUP.
            paddr_d  = APB_ADDR_WIDTH'({addr_hi_q, addr_lo_q});
            pwdata_d = {bus.rx_data_i, wdata_q[23:0]};
            cnt_d    = '0;
            state_d  = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_BYTE_MASTER_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          rdata_d  = bus.PRDATA;
          status_d = bus.PSLVERR ? ST_ERR : ST_OK;
          cnt_d    = '0;
          state_d  = S_RESP;
        end
`ifdef APB_BYTE_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d  = '0;
          status_d = ST_TMO;
          cnt_d    = '0;
          state_d  = S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (tx_fire) begin
          if (cnt_q == (pwrite_q ? 3'd0 : 3'd4)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    psel_d     = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d  = (state_d == S_ACCESS);
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR0) ||
                 (state_d == S_ADDR1) || (state_d == S_DATA);
    tx_valid_d = (state_d == S_RESP);
    busy_d     = (state_d != S_IDLE);

    unique case (cnt_d)
      3'd1:    tx_data_d = rdata_d[7:0];
      3'd2:    tx_data_d = rdata_d[15:8];
      3'd3:    tx_data_d = rdata_d[23:16];
      3'd4:    tx_data_d = rdata_d[31:24];
      default: tx_data_d = status_d;
    endcase
    if (state_d != S_RESP) tx_data_d = tx_data_q;
  end

  assign bus.rx_ready_o = rx_ready_q;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.tx_valid_o = tx_valid_q;
  assign bus.PADDR      = paddr_q;
  assign bus.PWDATA     = pwdata_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PSEL       = psel_q;
  assign bus.PENABLE    = penable_q;
  assign busy_o         = busy_q;

endmodule
